// File: rtl/register_write_arbiter_pkg.sv
// Shared types and constants for the two-requester register write arbiter.
package register_write_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    localparam logic TARGET_FIRST  = 1'b0;
    localparam logic TARGET_SECOND = 1'b1;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/register_write_arbiter_picker.sv
// Combinational round-robin choice between requesters A and B.
module round_robin_picker
    import register_write_arbiter_pkg::*;
(
    input  logic [1:0] request,
    input  logic       pointer,
    output logic [1:0] winner,
    output logic       valid
);

    // pointer = 0 favours A, 1 favours B; a lone requester always wins
    always_comb begin
        winner = '0;
        valid  = |request;
        if (request[REQ_A] && (!request[REQ_B] || pointer == 1'b0))
            winner[REQ_A] = 1'b1;
        else if (request[REQ_B])
            winner[REQ_B] = 1'b1;
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter for a shared register pair with confirm timeout.
// Define REGISTER_WRITE_COUNT_EN to add saturating strobe/timeout counters.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned TIMEOUT       = 15,
    parameter int unsigned TIMEOUT_WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       request,
    input  logic [1:0]       confirm,
    input  logic [1:0]       target,
    input  logic [WIDTH-1:0] data_a_in,
    input  logic [WIDTH-1:0] data_b_in,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             first_enable,
    output logic             second_enable,
`ifdef REGISTER_WRITE_COUNT_EN
    output logic [7:0]       first_write_count,
    output logic [7:0]       second_write_count,
    output logic [7:0]       timeout_count,
`endif
    output logic             timeout_flag
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_t                   state;
    logic                     pointer;
    logic                     owner;
    logic                     captured_target;
    logic [TIMEOUT_WIDTH-1:0] wait_count;
    logic [1:0]               winner;
    logic                     valid;

    round_robin_picker picker (
        .request (request),
        .pointer (pointer),
        .winner  (winner),
        .valid   (valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            grant           <= '0;
            busy            <= 1'b0;
            data_out        <= '0;
            first_enable    <= 1'b0;
            second_enable   <= 1'b0;
            timeout_flag    <= 1'b0;
            pointer         <= 1'b0;
            owner           <= 1'b0;
            captured_target <= 1'b0;
            wait_count      <= '0;
        end else begin
            first_enable  <= 1'b0;
            second_enable <= 1'b0;
            timeout_flag  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        state      <= GRANT;
                        grant      <= winner;
                        owner      <= winner[REQ_B];
                        wait_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    // withdrawal outranks confirm; confirm outranks timeout
                    if (!request[owner]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (confirm[owner]) begin
                        state           <= WRITE;
                        grant           <= '0;
                        data_out        <= owner ? data_b_in : data_a_in;
                        captured_target <= target[owner];
                    end else if (wait_count == LAST_WAIT) begin
                        state        <= IDLE;
                        grant        <= '0;
                        busy         <= 1'b0;
                        timeout_flag <= 1'b1;
                        pointer      <= ~owner;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                WRITE: begin
                    // first WRITE cycle raises the strobe, second retires it
                    if (first_enable || second_enable) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pointer <= ~owner;
                    end else begin
                        first_enable  <= (captured_target == TARGET_FIRST);
                        second_enable <= (captured_target == TARGET_SECOND);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGISTER_WRITE_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_write_count  <= '0;
            second_write_count <= '0;
            timeout_count      <= '0;
        end else begin
            if (first_enable)  first_write_count  <= sat_inc(first_write_count);
            if (second_enable) second_write_count <= sat_inc(second_write_count);
            if (timeout_flag)  timeout_count      <= sat_inc(timeout_count);
        end
    end
`endif

endmodule

// File: tb/tb_register_write_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random vs reference model.
module tb_register_write_arbiter;

    localparam int W  = 4;
    localparam int TO = 15;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   request, confirm, target;
    logic [W-1:0] data_a_in, data_b_in;
    logic [1:0]   grant;
    logic         busy, first_enable, second_enable, timeout_flag;
    logic [W-1:0] data_out;

    always #5 clock = ~clock;

    register_write_arbiter #(.WIDTH(W), .TIMEOUT(TO), .TIMEOUT_WIDTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .request(request), .confirm(confirm),
        .target(target), .data_a_in(data_a_in), .data_b_in(data_b_in),
        .grant(grant), .busy(busy), .data_out(data_out),
        .first_enable(first_enable), .second_enable(second_enable),
        .timeout_flag(timeout_flag)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds the grant, how long, and where a write stands.
    int           m_owner, m_age, m_ptr, m_win, m_write;
    logic         m_tgt;
    logic [W-1:0] m_data;
    logic [1:0]   e_grant;
    logic         e_busy, e_first, e_second, e_to;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_ptr = 0; m_win = 0; m_write = 0;
        m_tgt = 1'b0; m_data = '0;
        e_grant = '0; e_busy = 0; e_first = 0; e_second = 0; e_to = 0;
    endtask

    task automatic model_step(input logic [1:0] req, conf, tgt, input logic [W-1:0] da, db);
        e_first = 0; e_second = 0; e_to = 0;
        if (m_write == 2) begin
            if (m_tgt) e_second = 1; else e_first = 1;
            m_write = 1;
        end else if (m_write == 1) begin
            m_ptr = 1 - m_win;
            m_write = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) m_owner = -1;
            else if (conf[m_owner]) begin
                m_win = m_owner;
                m_data = (m_owner == 1) ? db : da;
                m_tgt = tgt[m_owner];
                m_write = 2;
                m_owner = -1;
            end else if (m_age + 1 == TO) begin
                e_to = 1;
                m_ptr = 1 - m_owner;
                m_owner = -1;
            end else m_age++;
        end else if (req != 2'b00) begin
            m_owner = (req == 2'b11) ? m_ptr : ((req == 2'b01) ? 0 : 1);
            m_age = 0;
        end
        e_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        e_busy = (m_owner >= 0) || (m_write != 0);
    endtask

    task automatic check_model(input string name);
        vectors++;
        if (grant !== e_grant || busy !== e_busy || data_out !== m_data ||
            first_enable !== e_first || second_enable !== e_second || timeout_flag !== e_to) begin
            miscompares++;
            $display("FAIL %s @%0t: got grant=%b busy=%b data=%h en=%b%b to=%b, want grant=%b busy=%b data=%h en=%b%b to=%b",
                     name, $time, grant, busy, data_out, first_enable, second_enable, timeout_flag,
                     e_grant, e_busy, m_data, e_first, e_second, e_to);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [1:0] req, conf, tgt, input logic [W-1:0] da, db);
        request = req; confirm = conf; target = tgt; data_a_in = da; data_b_in = db;
    endtask

    task automatic cycle(input logic [1:0] req, conf, tgt, input logic [W-1:0] da, db, input string name);
        drive(req, conf, tgt, da, db);
        @(posedge clock);
        model_step(req, conf, tgt, da, db);
        #1;
        check_model(name);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, '0, '0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model("reset");
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]   req, conf, tgt;
        logic [W-1:0] da;
        logic [1:0]   grant;
        logic         first, second;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int grants_seen, pulses, strobes, firsts;
        logic [1:0] seq[$];
        logic [1:0] prev;

        // A writes 4'hA to the second register, confirm on the third cycle
        tbl[0] = '{2'b01, 2'b00, 2'b01, 4'hA, 2'b01, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{2'b01, 2'b00, 2'b01, 4'hA, 2'b01, 1'b0, 1'b0, 4'h0};
        tbl[2] = '{2'b01, 2'b01, 2'b01, 4'hA, 2'b00, 1'b0, 1'b0, 4'hA};
        tbl[3] = '{2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b1, 4'hA};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 4'hA};
        tbl[5] = '{2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 4'hA};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].req, tbl[i].conf, tbl[i].tgt, tbl[i].da, 4'h5);
            @(posedge clock);
            model_step(tbl[i].req, tbl[i].conf, tbl[i].tgt, tbl[i].da, 4'h5);
            #1;
            vectors++;
            if (grant !== tbl[i].grant || first_enable !== tbl[i].first ||
                second_enable !== tbl[i].second || data_out !== tbl[i].data || timeout_flag !== 1'b0) begin
                miscompares++;
                $display("FAIL table[%0d]: got grant=%b en=%b%b data=%h to=%b, want grant=%b en=%b%b data=%h to=0",
                         i, grant, first_enable, second_enable, data_out, timeout_flag,
                         tbl[i].grant, tbl[i].first, tbl[i].second, tbl[i].data);
            end
        end

        // both requesting, confirm held: grants alternate A, B, A
        do_reset();
        prev = 2'b00;
        for (int i = 0; i < 10; i++) begin
            cycle(2'b11, 2'b11, 2'b00, 4'h3, 4'hC, "alternate");
            if (grant != 2'b00 && prev == 2'b00) seq.push_back(grant);
            prev = grant;
        end
        check_int("alternate_count", seq.size(), 3);
        if (seq.size() >= 3) begin
            check_int("alternate_0", int'(seq[0]), 1);
            check_int("alternate_1", int'(seq[1]), 2);
            check_int("alternate_2", int'(seq[2]), 1);
        end
        repeat (4) cycle(2'b00, 2'b00, 2'b00, '0, '0, "alternate_idle");

        // B never confirms: 15 grant cycles, one timeout pulse, no strobe
        do_reset();
        grants_seen = 0; pulses = 0; strobes = 0;
        for (int i = 0; i < 19; i++) begin
            cycle((i < 16) ? 2'b10 : 2'b00, 2'b00, 2'b11, 4'h1, 4'h2, "timeout");
            if (grant == 2'b10) grants_seen++;
            if (timeout_flag) pulses++;
            if (first_enable || second_enable) strobes++;
        end
        check_int("timeout_grant_cycles", grants_seen, 15);
        check_int("timeout_pulses", pulses, 1);
        check_int("timeout_strobes", strobes, 0);
        check_int("timeout_busy_after", int'(busy), 0);

        // A withdraws before confirming: pointer stays on A
        do_reset();
        cycle(2'b01, 2'b00, 2'b00, 4'h7, 4'h8, "abort");
        cycle(2'b01, 2'b00, 2'b00, 4'h7, 4'h8, "abort");
        cycle(2'b00, 2'b00, 2'b00, 4'h7, 4'h8, "abort_drop");
        check_int("abort_grant_cleared", int'(grant), 0);
        cycle(2'b11, 2'b00, 2'b00, 4'h7, 4'h8, "abort_regrant");
        check_int("abort_pointer_a", int'(grant), 1);
        cycle(2'b00, 2'b00, 2'b00, 4'h7, 4'h8, "abort_idle");

        // confirm on the wrong bit is ignored
        do_reset();
        strobes = 0; firsts = 0;
        cycle(2'b01, 2'b00, 2'b00, 4'h9, 4'h6, "wrong_confirm");
        for (int i = 0; i < 5; i++) cycle(2'b01, 2'b10, 2'b00, 4'h9, 4'h6, "wrong_confirm");
        check_int("wrong_confirm_still_granted", int'(grant), 1);
        cycle(2'b01, 2'b01, 2'b00, 4'h9, 4'h6, "right_confirm");
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00, 2'b00, 2'b00, 4'h0, 4'h0, "wrong_confirm_tail");
            if (first_enable || second_enable) strobes++;
            if (first_enable) firsts++;
        end
        check_int("wrong_confirm_strobes", strobes, 1);
        check_int("wrong_confirm_first", firsts, 1);

        // reset during the strobe cycle clears outputs at once
        do_reset();
        cycle(2'b01, 2'b00, 2'b00, 4'hA, 4'h0, "reset_mid");
        cycle(2'b01, 2'b01, 2'b00, 4'hA, 4'h0, "reset_mid");
        cycle(2'b00, 2'b00, 2'b00, 4'hA, 4'h0, "reset_mid_strobe");
        reset_n = 1'b0;
        #1;
        check_int("reset_async_enable", int'(first_enable | second_enable), 0);
        check_int("reset_async_grant", int'(grant), 0);
        check_int("reset_async_data", int'(data_out), 0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(2'b00, 2'b00, 2'b00, 4'hF, 4'hF, "reset_after");

        // randomized traffic against the reference model
        do_reset();
        begin
            logic [1:0] req_r;
            req_r = 2'b00;
            for (int i = 0; i < 600; i++) begin
                logic [1:0] conf_r;
                if ($urandom_range(0, 5) == 0) req_r = 2'($urandom_range(0, 3));
                conf_r[0] = ($urandom_range(0, 9) == 0);
                conf_r[1] = ($urandom_range(0, 9) == 0);
                cycle(req_r, conf_r, 2'($urandom_range(0, 3)),
                      W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
